// File: rtl/xswitch_pkg.sv
// Shared constants, types and helpers for the xswitch output arbiters.
// WDOG_LIMIT is only consumed when XSW_ARB_WDOG_EN is defined.
package xswitch_pkg;

    localparam int NPORTS     = 4;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = $clog2(NPORTS);
    localparam int WDOG_LIMIT = 15;

    typedef logic [ADDR_W-1:0] port_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // Round-robin successor, explicit wrap so non-power-of-two NPORTS stays correct.
    function automatic port_idx_t rr_next(input port_idx_t idx);
        if (int'(idx) == NPORTS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/xswitch_rr_arb.sv
// Round-robin arbiter FSM for a single output port: grant scan, lock and optional
// stall watchdog (enabled by defining XSW_ARB_WDOG_EN).
module xswitch_rr_arb
    import xswitch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              data_rd,
    output logic              grant_vld,
    output port_idx_t         grant_idx,
    output logic              wdog_to
);

    arb_state_t state_q, state_d;
    port_idx_t  rr_ptr_q, rr_ptr_d;
    port_idx_t  lock_q, lock_d;
    port_idx_t  scan_idx, cand;
    logic       scan_hit;

`ifdef XSW_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

    // Descending sweep so the requester closest to rr_ptr is the last (winning) write.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = rr_ptr_q;
        cand     = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            cand = rr_ptr_q + port_idx_t'(k);
            if (req[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        wdog_to   = 1'b0;
`ifdef XSW_ARB_WDOG_EN
        wdog_cnt_d = '0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (scan_hit) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                    if (data_rd) begin
                        rr_ptr_d = rr_next(scan_idx);
                    end else begin
                        state_d = ARB_BUSY;
                        lock_d  = scan_idx;
                    end
                end
            end
            ARB_BUSY: begin
                if (!req[lock_q]) begin
                    // Requester withdrew: release without advancing the pointer.
                    state_d = ARB_IDLE;
`ifdef XSW_ARB_WDOG_EN
                end else if (wdog_cnt_q == WDOG_MAX) begin
                    wdog_to  = 1'b1;
                    state_d  = ARB_IDLE;
                    rr_ptr_d = rr_next(lock_q);
`endif
                end else begin
                    grant_vld = 1'b1;
                    grant_idx = lock_q;
                    if (data_rd) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = rr_next(lock_q);
                    end else begin
`ifdef XSW_ARB_WDOG_EN
                        wdog_cnt_d = wdog_cnt_q + 1'b1;
`endif
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            lock_q     <= '0;
`ifdef XSW_ARB_WDOG_EN
            wdog_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
`ifdef XSW_ARB_WDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
`endif
        end
    end

endmodule

// File: rtl/xswitch_out_arbiter.sv
// Per-output round-robin scheduler for the 4x4 xswitch: request decode, output muxes
// and rcv_rdy merge. Optional stall watchdog enabled by defining XSW_ARB_WDOG_EN.
module xswitch_out_arbiter
    import xswitch_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        valid_in,
    input  logic [NPORTS*ADDR_W-1:0] addr_in,
    input  logic [NPORTS*DATA_W-1:0] data_in,
    output logic [NPORTS-1:0]        rcv_rdy,
    output logic [NPORTS-1:0]        valid_out,
    output logic [NPORTS*ADDR_W-1:0] addr_out,
    output logic [NPORTS*DATA_W-1:0] data_out,
    input  logic [NPORTS-1:0]        data_rd,
    output logic [NPORTS-1:0]        wdog_to
);

    logic [NPORTS-1:0] req [NPORTS];
    logic [NPORTS-1:0] gnt_vld;
    logic [NPORTS-1:0] wdog_raw;
    port_idx_t         gnt_idx [NPORTS];

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req[o][i] = valid_in[i] && (addr_in[i*ADDR_W +: ADDR_W] == port_idx_t'(o));
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        xswitch_rr_arb u_arb (
            .clk       (clk),
            .reset     (reset),
            .req       (req[o]),
            .data_rd   (data_rd[o]),
            .grant_vld (gnt_vld[o]),
            .grant_idx (gnt_idx[o]),
            .wdog_to   (wdog_raw[o])
        );
    end

    // Outputs are held at zero for the whole time reset is asserted.
    always_comb begin
        rcv_rdy   = '0;
        valid_out = '0;
        addr_out  = '0;
        data_out  = '0;
        wdog_to   = '0;
        if (reset) begin
            for (int o = 0; o < NPORTS; o++) begin
                wdog_to[o] = wdog_raw[o];
                if (gnt_vld[o]) begin
                    valid_out[o]                  = 1'b1;
                    addr_out[o*ADDR_W +: ADDR_W]  = gnt_idx[o];
                    data_out[o*DATA_W +: DATA_W]  = data_in[gnt_idx[o]*DATA_W +: DATA_W];
                    if (data_rd[o]) begin
                        rcv_rdy[gnt_idx[o]] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xswitch_out_arbiter.sv
// Directed bench for xswitch_out_arbiter with a per-cycle reference model of the
// round-robin/lock rules; follows XSW_ARB_WDOG_EN for the watchdog scenario.
module tb_xswitch_out_arbiter;

    localparam int NP   = 4;
    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int LIMIT = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   valid_in;
    logic [NP*AW-1:0] addr_in;
    logic [NP*DW-1:0] data_in;
    logic [NP-1:0]   rcv_rdy;
    logic [NP-1:0]   valid_out;
    logic [NP*AW-1:0] addr_out;
    logic [NP*DW-1:0] data_out;
    logic [NP-1:0]   data_rd;
    logic [NP-1:0]   wdog_to;

    int checks = 0;
    int errors = 0;

    xswitch_out_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .rcv_rdy   (rcv_rdy),
        .valid_out (valid_out),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .data_rd   (data_rd),
        .wdog_to   (wdog_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner = -1 means the output is free.
    int owner [NP] = '{-1, -1, -1, -1};
    int ptr   [NP] = '{0, 0, 0, 0};
    int stall [NP] = '{0, 0, 0, 0};

    function automatic bit requests(int i, int o);
        return valid_in[i] && (int'(addr_in[i*AW +: AW]) == o);
    endfunction

    initial begin : model
        int nowner [NP];
        int nptr   [NP];
        int nstall [NP];
        logic [NP-1:0]    e_v, e_rcv, e_wd;
        logic [NP*AW-1:0] e_a;
        logic [NP*DW-1:0] e_d;
        forever begin
            @(negedge clk);
            e_v = '0; e_rcv = '0; e_wd = '0; e_a = '0; e_d = '0;
            for (int o = 0; o < NP; o++) begin
                int g;
                bit to;
                g  = -1;
                to = 0;
                nowner[o] = -1;
                nptr[o]   = ptr[o];
                nstall[o] = 0;
                if (!reset) begin
                    nptr[o] = 0;
                    continue;
                end
                if (owner[o] >= 0) begin
                    if (requests(owner[o], o)) begin
`ifdef XSW_ARB_WDOG_EN
                        if (stall[o] == LIMIT) to = 1;
                        else g = owner[o];
`else
                        g = owner[o];
`endif
                    end
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        if (g < 0 && requests((ptr[o] + k) % NP, o)) g = (ptr[o] + k) % NP;
                    end
                end
                if (g >= 0) begin
                    e_v[o] = 1'b1;
                    e_a[o*AW +: AW] = AW'(g);
                    e_d[o*DW +: DW] = data_in[g*DW +: DW];
                    if (data_rd[o]) begin
                        e_rcv[g] = 1'b1;
                        nptr[o]  = (g + 1) % NP;
                    end else begin
                        nowner[o] = g;
                        nstall[o] = (owner[o] >= 0) ? stall[o] + 1 : 0;
                    end
                end else if (to) begin
                    e_wd[o] = 1'b1;
                    nptr[o] = (owner[o] + 1) % NP;
                end
            end
            chk("valid_out", 32'(valid_out), 32'(e_v));
            chk("addr_out",  32'(addr_out),  32'(e_a));
            chk("data_out",  32'(data_out),  32'(e_d));
            chk("rcv_rdy",   32'(rcv_rdy),   32'(e_rcv));
            chk("wdog_to",   32'(wdog_to),   32'(e_wd));
            @(posedge clk);
            owner = nowner;
            ptr   = nptr;
            stall = nstall;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = '0;
        addr_in  = '0;
        data_in  = '0;
        data_rd  = '0;
    endtask

    initial begin : stim
        int wd_pulses;
        int rcv0;
        int vcycles;
        reset = 1'b0;
        valid_in = 4'hF;
        addr_in  = 8'hE4;
        data_in  = 32'hDEADBEEF;
        data_rd  = 4'hF;
        step();
        step();
        @(negedge clk);
        chk("reset_valid_out", 32'(valid_out), 32'h0);
        chk("reset_rcv_rdy",   32'(rcv_rdy),   32'h0);
        chk("reset_data_out",  32'(data_out),  32'h0);
        step();
        reset = 1'b1;
        idle_inputs();
        step();

        // Single path: in0 -> out2, accepted immediately.
        valid_in = 4'b0001;
        addr_in  = 8'b00_00_00_10;
        data_in  = 32'h000000A5;
        data_rd  = 4'b0100;
        @(negedge clk);
        chk("single_valid2", 32'(valid_out[2]), 32'h1);
        chk("single_addr2",  32'(addr_out[5:4]), 32'h0);
        chk("single_data2",  32'(data_out[23:16]), 32'hA5);
        chk("single_rcv",    32'(rcv_rdy), 32'b0001);
        step();
        idle_inputs();
        step();

        // Contention: all four inputs on out1, consumer always ready.
        valid_in = 4'hF;
        addr_in  = 8'b01_01_01_01;
        data_in  = 32'h33221100;
        data_rd  = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("contend_addr1", 32'(addr_out[3:2]), 32'(k % 4));
            chk("contend_rcv",   32'(rcv_rdy), 32'(1 << (k % 4)));
            step();
        end
        idle_inputs();
        step();

        // Lock hold: in1 and in3 on out0, consumer stalled.
        valid_in = 4'b1010;
        addr_in  = 8'h00;
        data_in  = 32'h44003300;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lock_addr0", 32'(addr_out[1:0]), 32'h1);
            chk("lock_rcv",   32'(rcv_rdy), 32'h0);
            step();
        end
        data_rd = 4'b0001;
        @(negedge clk);
        chk("lock_release_rcv", 32'(rcv_rdy), 32'b0010);
        step();
        @(negedge clk);
        chk("lock_next_addr0", 32'(addr_out[1:0]), 32'h3);
        chk("lock_next_rcv",   32'(rcv_rdy), 32'b1000);
        step();
        idle_inputs();
        step();

        // Drop: in2 locks out3, in0 joins, then in2 withdraws.
        valid_in = 4'b0100;
        addr_in  = 8'b00_11_00_00;
        data_in  = 32'h00C00011;
        @(negedge clk);
        chk("drop_first_addr3", 32'(addr_out[7:6]), 32'h2);
        step();
        valid_in = 4'b0101;
        addr_in  = 8'b00_11_00_11;
        @(negedge clk);
        chk("drop_held_addr3", 32'(addr_out[7:6]), 32'h2);
        step();
        valid_in = 4'b0001;
        @(negedge clk);
        chk("drop_release_valid3", 32'(valid_out[3]), 32'h0);
        step();
        @(negedge clk);
        chk("drop_regrant_valid3", 32'(valid_out[3]), 32'h1);
        chk("drop_regrant_addr3",  32'(addr_out[7:6]), 32'h0);
        step();
        idle_inputs();
        step();

        // Reset in the middle of a locked transfer.
        valid_in = 4'b0010;
        data_in  = 32'h00007700;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_valid", 32'(valid_out), 32'h0);
        chk("midreset_rcv",   32'(rcv_rdy), 32'h0);
        step();
        reset = 1'b1;
        valid_in = 4'b1001;
        addr_in  = 8'h00;
        data_in  = 32'h30000010;
        @(negedge clk);
        chk("postreset_valid0", 32'(valid_out[0]), 32'h1);
        chk("postreset_addr0",  32'(addr_out[1:0]), 32'h0);
        step();
        idle_inputs();
        step();

        // Stray data_rd with nothing to accept.
        data_rd = 4'hF;
        @(negedge clk);
        chk("stray_rd_rcv", 32'(rcv_rdy), 32'h0);
        step();

        // Two outputs completing on the same cycle.
        valid_in = 4'b0011;
        addr_in  = 8'b00_00_01_00;
        data_in  = 32'h0000BBAA;
        data_rd  = 4'b0011;
        @(negedge clk);
        chk("dual_rcv", 32'(rcv_rdy), 32'b0011);
        chk("dual_data", 32'(data_out[15:0]), 32'hBBAA);
        step();
        idle_inputs();
        step();

        // Stalled lock: in0 -> out1, consumer never ready.
        valid_in = 4'b0001;
        addr_in  = 8'b00_00_00_01;
        data_in  = 32'h0000005A;
        wd_pulses = 0;
        rcv0      = 0;
        vcycles   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wd_pulses += int'(wdog_to[1]);
            rcv0      += int'(rcv_rdy[0]);
            vcycles   += int'(valid_out[1]);
            step();
        end
`ifdef XSW_ARB_WDOG_EN
        chk("wdog_pulses",  32'(wd_pulses), 32'd1);
        chk("wdog_vcycles", 32'(vcycles), 32'd19);
`else
        chk("wdog_pulses",  32'(wd_pulses), 32'd0);
        chk("wdog_vcycles", 32'(vcycles), 32'd20);
`endif
        chk("wdog_no_rcv", 32'(rcv0), 32'd0);
        idle_inputs();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
